// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
//   Sits downstream of the LIF neuron. It only advances on cycles where the
//   neuron actually stepped its membrane (spike_valid=1). It produces two
//   measurements:
//     - rate: a saturating spike count over a window of window_len+1 steps,
//       published once per window.
//     - isi : the inter-spike interval, in steps, between consecutive spikes.
//
// Ports
//   clk          in   1            rising-edge clock
//   reset        in   1            synchronous, active-high reset
//   spike_valid  in   1            neuron performed a membrane step this cycle
//   spike        in   1            neuron spike, used only when spike_valid=1
//   window_len   in   WINDOW_BITS  window length minus one, latched at window start
//   rate         out  COUNT_BITS   spike count of the last completed window
//   rate_valid   out  1            one-cycle pulse when rate/overflow update
//   overflow     out  1            last completed window's count saturated
//   isi          out  ISI_BITS     steps between the last two spikes
//   isi_valid    out  1            one-cycle pulse when isi updates
// -----------------------------------------------------------------------------
module spike_rate_decoder #(
   parameter int WINDOW_BITS = 6,
   parameter int COUNT_BITS  = 7,
   parameter int ISI_BITS    = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   spike_valid,
   input  logic                   spike,
   input  logic [WINDOW_BITS-1:0] window_len,
   output logic [COUNT_BITS-1:0]  rate,
   output logic                   rate_valid,
   output logic                   overflow,
   output logic [ISI_BITS-1:0]    isi,
   output logic                   isi_valid
);

   // Window FSM states. The state is not stored: it is decoded from the step
   // counter, since the closing step is simply the one where the counter has
   // reached the latched window length.
   localparam logic [0:0] ST_COUNT = 1'b0;
   localparam logic [0:0] ST_CLOSE = 1'b1;

   localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;
   localparam logic [ISI_BITS-1:0]   ISI_MAX = '1;

   // Saturating add of a single spike to the window count.
   // Returns {clipped, sum}; clipped is set when the increment was lost.
   function automatic logic [COUNT_BITS:0] sat_add_cnt(
      input logic [COUNT_BITS-1:0] a,
      input logic                  inc
   );
      if (inc && (a == CNT_MAX)) begin
         return {1'b1, a};
      end
      return {1'b0, a + COUNT_BITS'(inc)};
   endfunction

   // Saturating increment of the ISI counter; sticks at all-ones.
   function automatic logic [ISI_BITS-1:0] sat_inc_isi(
      input logic [ISI_BITS-1:0] a
   );
      if (a == ISI_MAX) begin
         return a;
      end
      return a + ISI_BITS'(1);
   endfunction

   logic [WINDOW_BITS-1:0] step_cnt_q,  step_cnt_d;
   logic [COUNT_BITS-1:0]  spike_cnt_q, spike_cnt_d;
   logic                   sat_q,       sat_d;
   logic [WINDOW_BITS-1:0] win_len_q,   win_len_d;
   logic [ISI_BITS-1:0]    isi_cnt_q,   isi_cnt_d;
   logic                   seen_q,      seen_d;
   logic [COUNT_BITS-1:0]  rate_q,      rate_d;
   logic                   rate_vld_q,  rate_vld_d;
   logic                   ovf_q,       ovf_d;
   logic [ISI_BITS-1:0]    isi_q,       isi_d;
   logic                   isi_vld_q,   isi_vld_d;

   logic [0:0]             state;
   logic [COUNT_BITS:0]    cnt_add;

   always_comb begin
      step_cnt_d  = step_cnt_q;
      spike_cnt_d = spike_cnt_q;
      sat_d       = sat_q;
      win_len_d   = win_len_q;
      isi_cnt_d   = isi_cnt_q;
      seen_d      = seen_q;
      rate_d      = rate_q;
      ovf_d       = ovf_q;
      isi_d       = isi_q;
      rate_vld_d  = 1'b0;
      isi_vld_d   = 1'b0;

      state   = (step_cnt_q == win_len_q) ? ST_CLOSE : ST_COUNT;
      cnt_add = sat_add_cnt(spike_cnt_q, spike);

      if (spike_valid) begin
         // Window counting. A spike on the closing step belongs to the
         // window being closed, so it is folded into the published rate.
         if (state == ST_CLOSE) begin
            rate_d      = cnt_add[COUNT_BITS-1:0];
            ovf_d       = sat_q | cnt_add[COUNT_BITS];
            rate_vld_d  = 1'b1;
            step_cnt_d  = '0;
            spike_cnt_d = '0;
            sat_d       = 1'b0;
            win_len_d   = window_len;
         end else begin
            step_cnt_d  = step_cnt_q + WINDOW_BITS'(1);
            spike_cnt_d = cnt_add[COUNT_BITS-1:0];
            sat_d       = sat_q | cnt_add[COUNT_BITS];
         end

         // ISI tracking. The counter holds steps since the last spike
         // excluding the spiking step itself, hence the +1 on report.
         if (spike) begin
            if (seen_q) begin
               isi_d     = sat_inc_isi(isi_cnt_q);
               isi_vld_d = 1'b1;
            end
            isi_cnt_d = '0;
            seen_d    = 1'b1;
         end else begin
            isi_cnt_d = sat_inc_isi(isi_cnt_q);
         end
      end
   end

   // Register stage: all state and outputs update here.
   always_ff @(posedge clk) begin
      if (reset) begin
         step_cnt_q  <= '0;
         spike_cnt_q <= '0;
         sat_q       <= 1'b0;
         win_len_q   <= window_len;
         isi_cnt_q   <= '0;
         seen_q      <= 1'b0;
         rate_q      <= '0;
         rate_vld_q  <= 1'b0;
         ovf_q       <= 1'b0;
         isi_q       <= '0;
         isi_vld_q   <= 1'b0;
      end else begin
         step_cnt_q  <= step_cnt_d;
         spike_cnt_q <= spike_cnt_d;
         sat_q       <= sat_d;
         win_len_q   <= win_len_d;
         isi_cnt_q   <= isi_cnt_d;
         seen_q      <= seen_d;
         rate_q      <= rate_d;
         rate_vld_q  <= rate_vld_d;
         ovf_q       <= ovf_d;
         isi_q       <= isi_d;
         isi_vld_q   <= isi_vld_d;
      end
   end

   assign rate       = rate_q;
   assign rate_valid = rate_vld_q;
   assign overflow   = ovf_q;
   assign isi        = isi_q;
   assign isi_valid  = isi_vld_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_decoder
//   Directed stimulus with hand-computed expected results pushed into
//   queues; independent monitors pop and compare whenever a valid pulses.
//   A second instance with COUNT_BITS=4 exercises rate saturation.
// -----------------------------------------------------------------------------
module tb_spike_rate_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       spike_valid;
   logic       spike_valid4;
   logic       spike;
   logic [5:0] window_len;

   logic [6:0] rate;
   logic       rate_valid, overflow, isi_valid;
   logic [7:0] isi;

   logic [3:0] rate4;
   logic       rate_valid4, overflow4, isi_valid4;
   logic [7:0] isi4;

   spike_rate_decoder dut (
      .clk         (clk),
      .reset       (reset),
      .spike_valid (spike_valid),
      .spike       (spike),
      .window_len  (window_len),
      .rate        (rate),
      .rate_valid  (rate_valid),
      .overflow    (overflow),
      .isi         (isi),
      .isi_valid   (isi_valid)
   );

   spike_rate_decoder #(.COUNT_BITS(4)) dut4 (
      .clk         (clk),
      .reset       (reset),
      .spike_valid (spike_valid4),
      .spike       (spike),
      .window_len  (window_len),
      .rate        (rate4),
      .rate_valid  (rate_valid4),
      .overflow    (overflow4),
      .isi         (isi4),
      .isi_valid   (isi_valid4)
   );

   typedef struct {
      int r;
      int o;
   } rate_exp_t;

   rate_exp_t q_rate[$];
   rate_exp_t q_rate4[$];
   int        q_isi[$];
   rate_exp_t em, em4;
   int        ei;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitors: sample away from the active edge.
   always @(negedge clk) begin
      if (rate_valid) begin
         if (q_rate.size() == 0) begin
            check("rate_valid_unexpected", 1, 0);
         end else begin
            em = q_rate.pop_front();
            check("rate", int'(rate), em.r);
            check("overflow", int'(overflow), em.o);
         end
      end
      if (isi_valid) begin
         if (q_isi.size() == 0) begin
            check("isi_valid_unexpected", 1, 0);
         end else begin
            ei = q_isi.pop_front();
            check("isi", int'(isi), ei);
         end
      end
      if (rate_valid4) begin
         if (q_rate4.size() == 0) begin
            check("rate4_valid_unexpected", 1, 0);
         end else begin
            em4 = q_rate4.pop_front();
            check("rate4", int'(rate4), em4.r);
            check("overflow4", int'(overflow4), em4.o);
         end
      end
   end

   task automatic push_rate(input int r, input int o);
      rate_exp_t e;
      e.r = r;
      e.o = o;
      q_rate.push_back(e);
   endtask

   task automatic push_rate4(input int r, input int o);
      rate_exp_t e;
      e.r = r;
      e.o = o;
      q_rate4.push_back(e);
   endtask

   task automatic push_isi(input int v);
      q_isi.push_back(v);
   endtask

   task automatic step(input logic s);
      spike_valid = 1'b1;
      spike       = s;
      @(posedge clk);
      #1;
      spike_valid = 1'b0;
      spike       = 1'b0;
   endtask

   task automatic step4(input logic s);
      spike_valid4 = 1'b1;
      spike        = s;
      @(posedge clk);
      #1;
      spike_valid4 = 1'b0;
      spike        = 1'b0;
   endtask

   // Non-step cycle with the spike line high: must be ignored.
   task automatic idle();
      spike_valid = 1'b0;
      spike       = 1'b1;
      @(posedge clk);
      #1;
      spike = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rate"}, int'(rate), 0);
      check({tag, "_rate_valid"}, int'(rate_valid), 0);
      check({tag, "_overflow"}, int'(overflow), 0);
      check({tag, "_isi"}, int'(isi), 0);
      check({tag, "_isi_valid"}, int'(isi_valid), 0);
   endtask

   task automatic do_reset(input logic [5:0] wl);
      window_len   = wl;
      spike_valid  = 1'b0;
      spike_valid4 = 1'b0;
      spike        = 1'b0;
      reset        = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      spike_valid  = 1'b0;
      spike_valid4 = 1'b0;
      spike        = 1'b0;
      window_len   = 6'd3;

      // Reset state
      do_reset(6'd3);
      check_zero("reset");

      // Basic 4-step window: spikes 1,0,1,1
      push_rate(3, 0);
      push_isi(2);
      push_isi(1);
      step(1'b1); step(1'b0); step(1'b1); step(1'b1);
      #10;

      // Same with idle cycles carrying spike=1 between steps
      do_reset(6'd3);
      check_zero("reset2");
      push_rate(3, 0);
      push_isi(2);
      push_isi(1);
      step(1'b1); idle(); step(1'b0); idle(); idle();
      step(1'b1); idle(); step(1'b1);
      #10;

      // Saturation on the 4-bit count instance
      do_reset(6'd31);
      push_rate4(15, 1);
      for (int i = 0; i < 32; i++) step4(1'b1);
      push_rate4(2, 0);
      step4(1'b1);
      window_len = 6'd15;
      for (int i = 0; i < 30; i++) step4(1'b0);
      step4(1'b1);
      // 16 spikes: only the final closing add clips
      push_rate4(15, 1);
      for (int i = 0; i < 16; i++) step4(1'b1);
      // 15 spikes then a quiet closing step: exactly full, no clip
      push_rate4(15, 0);
      for (int i = 0; i < 15; i++) step4(1'b1);
      step4(1'b0);
      #10;

      // ISI: spikes on steps 0, 3, 8
      do_reset(6'd63);
      push_isi(3);
      push_isi(5);
      for (int i = 0; i < 9; i++) step((i == 0) || (i == 3) || (i == 8));
      #10;

      // ISI saturation; 64-step windows close along the way
      do_reset(6'd63);
      push_rate(1, 0);
      push_rate(0, 0);
      push_rate(0, 0);
      push_rate(0, 0);
      push_isi(255);
      step(1'b1);
      for (int i = 0; i < 300; i++) step(1'b0);
      step(1'b1);
      #10;

      // window_len change mid-window takes effect at next window
      do_reset(6'd3);
      push_rate(2, 0);
      push_rate(3, 0);
      push_isi(1);
      push_isi(3);
      push_isi(2);
      push_isi(5);
      step(1'b1);
      window_len = 6'd7;
      step(1'b1); step(1'b0); step(1'b0);
      step(1'b1); step(1'b0); step(1'b1);
      for (int i = 0; i < 4; i++) step(1'b0);
      step(1'b1);
      #10;

      // Reset mid-window discards the partial window
      do_reset(6'd3);
      push_isi(1);
      step(1'b1); step(1'b1);
      reset       = 1'b1;
      spike_valid = 1'b1;
      spike       = 1'b1;
      @(posedge clk);
      #1;
      reset       = 1'b0;
      spike_valid = 1'b0;
      spike       = 1'b0;
      check_zero("midreset");
      push_rate(1, 0);
      step(1'b0); step(1'b1); step(1'b0); step(1'b0);
      #10;

      // One-step windows
      do_reset(6'd0);
      push_rate(1, 0);
      push_rate(0, 0);
      push_rate(1, 0);
      push_isi(2);
      step(1'b1); step(1'b0); step(1'b1);

      repeat (3) @(posedge clk);
      #1;
      check("rate_queue_left", q_rate.size(), 0);
      check("rate4_queue_left", q_rate4.size(), 0);
      check("isi_queue_left", q_isi.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
